minimization_sweeper: RTL and testbench



---
 rtl/minimization_sweeper.sv | 165 ++++++++++++++++
 tb/tb_minimization_sweeper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/minimization_sweeper.sv
// ---------------------------------------------------------------------------
// minimization_sweeper
//   Self-test stage wrapped around the 3-in/2-out minimized logic unit.
//   Drives every input vector {i2,i1,i0} = 0..7 in order. Each vector is held
//   for SETTLE_CYCLES cycles, then the unit's response {o1_in,o0_in} is
//   compared against a built-in golden table for one CHECK cycle. Mismatches
//   are counted in err_cnt; done/pass report the result of the sweep.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector settles before sampling (1..15)
//   ERR_W         : error counter width (>= 4 so it can hold 8)
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : single-cycle sweep request (ignored while busy)
//   o1_in, o0_in  : response from the unit under check
//   i2, i1, i0    : registered stimulus to the unit
//   busy          : sweep in progress
//   done          : sweep finished, held until the next accepted start
//   pass          : done with zero mismatches
//   err_cnt       : mismatching vectors in the last sweep
//   vec_idx       : vector currently driven (== {i2,i1,i0})
//
// Optional feature (macro MINSWEEP_FAIL_LOG_EN)
//   Adds fail_valid/fail_idx/fail_obs capturing the first mismatch of a
//   sweep. Cleared on reset and on every accepted start.
// ---------------------------------------------------------------------------
module minimization_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             o1_in,
  input  logic             o0_in,
  output logic             i2,
  output logic             i1,
  output logic             i0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
`ifdef MINSWEEP_FAIL_LOG_EN
  output logic             fail_valid,
  output logic [2:0]       fail_idx,
  output logic [1:0]       fail_obs,
`endif
  output logic [2:0]       vec_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  // Expected {o1,o0} for each input vector of the minimized unit.
  function automatic logic [1:0] f_golden(input logic [2:0] idx);
    logic [1:0] v;
    case (idx)
      3'd0:    v = 2'b10;
      3'd1:    v = 2'b01;
      3'd2:    v = 2'b11;
      3'd3:    v = 2'b01;
      3'd4:    v = 2'b10;
      3'd5:    v = 2'b11;
      3'd6:    v = 2'b10;
      default: v = 2'b01;
    endcase
    return v;
  endfunction

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_vec;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_err;

  logic [1:0] w_obs;
  logic       w_miss;
  logic       w_accept;

  assign w_obs    = {o1_in, o0_in};
  // Inputs only matter in CHECK; anything seen during SETTLE is ignored.
  assign w_miss   = (r_state == ST_CHECK) && (w_obs != f_golden(r_vec));
  // start is honoured only when no sweep is running (IDLE or DONE).
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else if (w_accept) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_miss) r_err <= r_err + ERR_W'(1);
          if (r_vec == 3'd7) begin
            // Last vector: stop here, stimulus stays at vector 7.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vec   <= r_vec + 3'd1;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MINSWEEP_FAIL_LOG_EN
  logic       r_fail_valid;
  logic [2:0] r_fail_idx;
  logic [1:0] r_fail_obs;

  // First mismatch of the sweep wins; later ones leave the capture alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_obs   <= '0;
    end else if (w_accept) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_fail_obs   <= '0;
    end else if (w_miss && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_idx   <= r_vec;
      r_fail_obs   <= w_obs;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
  assign fail_obs   = r_fail_obs;
`endif

  assign {i2, i1, i0} = r_vec;
  assign vec_idx      = r_vec;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_cnt      = r_err;
  assign pass         = r_done && (r_err == '0);

endmodule

// File: tb/tb_minimization_sweeper.sv
// ---------------------------------------------------------------------------
// tb_minimization_sweeper
//   Bench-side model of the logic unit: response = golden[idx] ^ fault[idx],
//   where fault[] is chosen per sweep (clean, o0 stuck 0, o1 stuck 1, random).
//   Expected error count / first failure are derived from fault[] directly;
//   expected timing is vec = k / (SETTLE_CYCLES+1) for cycle k of the sweep.
// ---------------------------------------------------------------------------
module tb_minimization_sweeper;
  localparam int SC    = 2;
  localparam int ERR_W = 4;
  localparam int PER   = SC + 1;
  localparam int SWEEP = 8 * PER;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             o1_in, o0_in;
  logic             i2, i1, i0;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
  logic [2:0]       vec_idx;
`ifdef MINSWEEP_FAIL_LOG_EN
  logic             fail_valid;
  logic [2:0]       fail_idx;
  logic [1:0]       fail_obs;
`endif

  logic [1:0] gold  [8] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
  logic [1:0] fault [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Unit under check, modelled with injected faults.
  assign {o1_in, o0_in} = gold[{i2, i1, i0}] ^ fault[{i2, i1, i0}];

  minimization_sweeper #(.SETTLE_CYCLES(SC), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .o1_in(o1_in), .o0_in(o0_in),
    .i2(i2), .i1(i1), .i0(i0),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
`ifdef MINSWEEP_FAIL_LOG_EN
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_obs(fail_obs),
`endif
    .vec_idx(vec_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sweep from IDLE or DONE. pulse_k >= 0 injects a stray start
  // during cycle pulse_k of the sweep; hold keeps start high throughout.
  task automatic run_sweep(input int pulse_k, input bit hold);
    int         exp_err;
    int         first;
    logic [1:0] first_obs;
    exp_err   = 0;
    first     = -1;
    first_obs = 2'b00;
    for (int i = 0; i < 8; i++)
      if (fault[i] != 2'b00) begin
        exp_err++;
        if (first < 0) begin
          first     = i;
          first_obs = gold[i] ^ fault[i];
        end
      end

    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_err_clr", 32'(err_cnt), 32'd0);
`ifdef MINSWEEP_FAIL_LOG_EN
    chk("start_flog_clr", {31'd0, fail_valid}, 32'd0);
`endif
    for (int k = 0; k < SWEEP; k++) begin
      if (!hold) start = (k == pulse_k);
      chk("sweep_vec", 32'(vec_idx), 32'(k / PER));
      chk("sweep_stim", 32'({i2, i1, i0}), 32'(k / PER));
      chk("sweep_busy", {31'd0, busy}, 32'd1);
      chk("sweep_done", {31'd0, done}, 32'd0);
      tick();
    end
    if (!hold) start = 1'b0;
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_err", 32'(err_cnt), 32'(exp_err));
    chk("end_pass", {31'd0, pass}, {31'd0, exp_err == 0});
    chk("end_vec", 32'(vec_idx), 32'd7);
`ifdef MINSWEEP_FAIL_LOG_EN
    chk("flog_valid", {31'd0, fail_valid}, {31'd0, first >= 0});
    if (first >= 0) begin
      chk("flog_idx", 32'(fail_idx), 32'(first));
      chk("flog_obs", 32'(fail_obs), 32'(first_obs));
    end
`endif
    if (!hold) begin
      repeat (3) tick();
      chk("hold_done", {31'd0, done}, 32'd1);
      chk("hold_err", 32'(err_cnt), 32'(exp_err));
      chk("hold_vec", 32'(vec_idx), 32'd7);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) fault[i] = 2'b00;
    #12;
    chk("rst_stim", 32'({i2, i1, i0}), 32'd0);
    chk("rst_vec", 32'(vec_idx), 32'd0);
    chk("rst_flags", {29'd0, busy, done, pass}, 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Correct unit.
    run_sweep(-1, 1'b0);

    // o0 stuck at 0.
    for (int i = 0; i < 8; i++) fault[i] = gold[i] & 2'b01;
    run_sweep(-1, 1'b0);

    // o1 stuck at 1, plus a stray start while vector 3 is driven.
    for (int i = 0; i < 8; i++) fault[i] = ~gold[i] & 2'b10;
    run_sweep(3 * PER, 1'b0);

    // Random fault patterns and random stray starts.
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 8; i++)
        fault[i] = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
      run_sweep(int'($urandom_range(0, SWEEP - 2)), 1'b0);
    end

    // start held high: back-to-back sweeps, DONE lasts one cycle.
    for (int i = 0; i < 8; i++) fault[i] = 2'b00;
    fault[6] = 2'b11;
    run_sweep(-1, 1'b1);
    run_sweep(-1, 1'b1);
    tick();
    start = 1'b0;
    chk("b2b_restart_done", {31'd0, done}, 32'd0);
    chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
    chk("b2b_restart_vec", 32'(vec_idx), 32'd0);
    // Let that third sweep finish.
    repeat (SWEEP) tick();
    chk("b2b_third_done", {31'd0, done}, 32'd1);

    // Asynchronous reset mid-sweep at vector 5.
    for (int i = 0; i < 8; i++) fault[i] = gold[i] & 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * PER) tick();
    chk("mid_vec5", 32'(vec_idx), 32'd5);
    chk("mid_err", 32'(err_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_stim", 32'({i2, i1, i0}), 32'd0);
    chk("arst_vec", 32'(vec_idx), 32'd0);
    chk("arst_flags", {29'd0, busy, done, pass}, 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
`ifdef MINSWEEP_FAIL_LOG_EN
    chk("arst_flog", {31'd0, fail_valid}, 32'd0);
`endif
    #10;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_vec", 32'(vec_idx), 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
